ifq_dispatch: RTL and testbench

Read side of the instruction fetch queue. Pops 32-bit instructions from the fetch FIFO and holds them in a 2-entry skid buffer. Presents them to decode over a valid/ready handshake, tagged with their PC. On a resolved branch it discards everything queued, pulses a clear to the FIFO and fetch control, and restarts the PC at the branch target.

---
 rtl/ifq_pkg.sv | 32 +++
 rtl/ifq_skid_buf.sv | 73 +++++++
 rtl/ifq_dispatch.sv | 110 +++++++++++
 tb/tb_ifq_dispatch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: definitions shared by the instruction fetch queue read side
// (ifq_dispatch, ifq_skid_buf) and the fetch-side controller.
//   ifq_state_t     : dispatch FSM state encoding
//   IFQ_DATA_W      : default instruction width
//   IFQ_PC_W        : default program counter width
//   IFQ_RESET_PC    : default PC of the first instruction after reset
//   IFQ_INST_BYTES  : PC step per delivered instruction
//   ifq_credit_ok   : pop-credit check for a 2-entry skid buffer
package ifq_pkg;

  localparam int          IFQ_DATA_W     = 32;
  localparam int          IFQ_PC_W       = 32;
  localparam logic [31:0] IFQ_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IFQ_INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ifq_state_t;

  // A pop may be issued when the entries already held plus the one in
  // flight leave a free slot, or when decode frees a slot this cycle.
  function automatic logic ifq_credit_ok(input logic [1:0] cnt,
                                         input logic       inflight,
                                         input logic       consume);
    logic [2:0] used;
    used = {1'b0, cnt} + {2'b00, inflight};
    return (used < 3'd2) | consume;
  endfunction

endpackage

// File: rtl/ifq_skid_buf.sv
// ifq_skid_buf: 2-entry FIFO-ordered register buffer holding popped
// instructions until decode accepts them.
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : drop all entries (has priority over push/pop)
//   push        : write push_data at the tail
//   push_data   : data to write
//   pop         : advance the head (ignored when empty)
//   cnt         : number of valid entries (0..2)
//   head        : head entry data
//   head_valid  : cnt != 0
module ifq_skid_buf
  import ifq_pkg::*;
#(
  parameter int DATA_W = IFQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        cnt,
  output logic [DATA_W-1:0] head,
  output logic              head_valid
);

  logic [DATA_W-1:0] entry0;
  logic [DATA_W-1:0] entry1;
  logic              do_pop;

  assign do_pop     = pop & (cnt != 2'd0);
  assign head       = entry0;
  assign head_valid = (cnt != 2'd0);

  // entry0 is always the head; a pop shifts entry1 down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b11: begin
          if (cnt == 2'd2) begin
            entry0 <= entry1;
            entry1 <= push_data;
          end else begin
            entry0 <= push_data;
          end
        end
        2'b10: begin
          // A push into a full buffer cannot happen under the credit rule.
          if (cnt == 2'd0) begin
            entry0 <= push_data;
            cnt    <= 2'd1;
          end else if (cnt == 2'd1) begin
            entry1 <= push_data;
            cnt    <= 2'd2;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ifq_dispatch.sv
// ifq_dispatch: read side of the instruction fetch queue. Pops the fetch
// FIFO under a 2-slot credit, buffers in ifq_skid_buf, and hands
// instructions with their PC to decode over valid/ready. A resolved branch
// drops everything queued, pulses fifo_clear and restarts at the target.
//   clk, reset     : clock, asynchronous active-low reset
//   fifo_dout      : FIFO read data, valid the cycle after rd_enable
//   fifo_empty     : FIFO has no entries
//   rd_enable      : FIFO pop request
//   fifo_clear     : one-cycle pulse emptying FIFO / restarting fetch
//   branch_valid   : taken branch / redirect from execute
//   branch_target  : redirect PC
//   inst, inst_pc  : head instruction and its PC
//   inst_valid     : inst/inst_pc valid
//   inst_ready     : decode accepts
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RST   | first cycle after reset, no pops
// ST_RUN   | normal popping and delivery
// ST_FLUSH | one cycle absorbing the FIFO clear; no pops, nothing valid
module ifq_dispatch
  import ifq_pkg::*;
#(
  parameter int              DATA_W   = IFQ_DATA_W,
  parameter int              PC_W     = IFQ_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFQ_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              rd_enable,
  output logic              fifo_clear,
  input  logic              branch_valid,
  input  logic [PC_W-1:0]   branch_target,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(IFQ_INST_BYTES);

  ifq_state_t state;
  logic       inflight;
  logic [1:0] cnt;
  logic       head_valid;
  logic       consume;
  logic       redirect;
  logic       running;

  assign running  = (state == ST_RUN);
  assign redirect = branch_valid & (running | (state == ST_FLUSH));
  assign consume  = inst_valid & inst_ready;

  // Redirect must reach the FIFO in the same cycle so it stops producing
  // stale data before the next edge.
  assign fifo_clear = redirect;
  assign rd_enable  = running & ~fifo_empty & ~branch_valid &
                      ifq_credit_ok(cnt, inflight, consume);

  // The buffer is already empty outside RUN; gating keeps that explicit.
  assign inst_valid = head_valid & running;

  ifq_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect),
    .push       (inflight),
    .push_data  (fifo_dout),
    .pop        (consume),
    .cnt        (cnt),
    .head       (inst),
    .head_valid (head_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RST;
      inflight <= 1'b0;
      inst_pc  <= RESET_PC;
    end else begin
      // rd_enable is already 0 on a redirect, so in-flight data dies here.
      inflight <= rd_enable;
      case (state)
        ST_RST: begin
          state <= ST_RUN;
        end
        ST_RUN, ST_FLUSH: begin
          if (branch_valid) begin
            // Branch wins over a coincident consume: no PC step.
            state   <= ST_FLUSH;
            inst_pc <= branch_target;
          end else begin
            state <= ST_RUN;
            if (consume) begin
              inst_pc <= inst_pc + PC_STEP;
            end
          end
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifq_dispatch.sv
// tb_ifq_dispatch: per-cycle directed vectors for ifq_dispatch with a small
// FIFO model. A second instance with RESET_PC=32'hFFFF_FFF8 shares the
// stimulus to cover PC wrap.
module tb_ifq_dispatch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = '0;
  logic        inst_ready = 1'b1;
  logic        force_empty = 1'b0;

  logic        rd_enable, fifo_clear, inst_valid;
  logic [31:0] inst, inst_pc;
  logic        rd_enable_w, fifo_clear_w, inst_valid_w;
  logic [31:0] inst_w, inst_pc_w;

  logic [31:0] fmem [0:63];
  int          wptr = 0;
  int          rptr = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rptr == wptr) | force_empty;

  // FIFO model: registered read data, clear empties it.
  always @(posedge clk) begin
    if (fifo_clear) begin
      rptr <= wptr;
    end else if (rd_enable) begin
      fifo_dout <= fmem[rptr];
      rptr      <= rptr + 1;
    end
  end

  ifq_dispatch dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .rd_enable     (rd_enable),
    .fifo_clear    (fifo_clear),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready)
  );

  ifq_dispatch #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .rd_enable     (rd_enable_w),
    .fifo_clear    (fifo_clear_w),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst          (inst_w),
    .inst_pc       (inst_pc_w),
    .inst_valid    (inst_valid_w),
    .inst_ready    (inst_ready)
  );

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        fe;
    int          np;
    logic [31:0] pb;
    logic        e_rd;
    logic        e_clr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        c_wrap;
    logic [31:0] e_pc_w;
  } vec_t;

  vec_t vt [1:44];

  function automatic vec_t mkv(input logic rdy, input logic br,
                               input logic [31:0] tgt, input logic fe,
                               input int np, input logic [31:0] pb,
                               input logic rd, input logic clr,
                               input logic iv, input logic [31:0] ins,
                               input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.fe = fe; v.np = np; v.pb = pb;
    v.e_rd = rd; v.e_clr = clr; v.e_iv = iv; v.e_inst = ins; v.e_pc = pc;
    v.c_wrap = 1'b0; v.e_pc_w = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            rdy br tgt        fe np pb      rd clr iv inst     pc
    // reset release, FIFO preloaded A0..A2
    vt[1]  = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h0);
    vt[2]  = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h0);
    vt[3]  = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 1, 32'hA0, 32'h0);
    vt[4]  = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hA1, 32'h4);
    vt[5]  = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hA2, 32'h8);
    // stall 5 cycles, then drain B0..B3
    vt[6]  = mkv(0, 0, 32'h0,     0, 4, 32'hB0, 1, 0, 0, 32'h0,  32'hC);
    vt[7]  = mkv(0, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'hC);
    vt[8]  = mkv(0, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hB0, 32'hC);
    vt[9]  = mkv(0, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hB0, 32'hC);
    vt[10] = mkv(0, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hB0, 32'hC);
    vt[11] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 1, 32'hB0, 32'hC);
    vt[12] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 1, 32'hB1, 32'h10);
    vt[13] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hB2, 32'h14);
    vt[14] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hB3, 32'h18);
    // branch in RUN with one buffered and one in flight
    vt[15] = mkv(0, 0, 32'h0,     0, 4, 32'hC0, 1, 0, 0, 32'h0,  32'h1C);
    vt[16] = mkv(0, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h1C);
    vt[17] = mkv(0, 1, 32'h100,   0, 0, 32'h0,  0, 1, 1, 32'hC0, 32'h1C);
    vt[18] = mkv(1, 0, 32'h0,     0, 2, 32'hD0, 0, 0, 0, 32'h0,  32'h100);
    vt[19] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h100);
    vt[20] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h100);
    vt[21] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hD0, 32'h100);
    vt[22] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hD1, 32'h104);
    // branch with consume, then again during FLUSH
    vt[23] = mkv(1, 0, 32'h0,     0, 2, 32'hE0, 1, 0, 0, 32'h0,  32'h108);
    vt[24] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h108);
    vt[25] = mkv(1, 1, 32'h200,   0, 0, 32'h0,  0, 1, 1, 32'hE0, 32'h108);
    vt[26] = mkv(1, 1, 32'h300,   0, 0, 32'h0,  0, 1, 0, 32'h0,  32'h200);
    vt[27] = mkv(1, 0, 32'h0,     0, 1, 32'hF0, 0, 0, 0, 32'h0,  32'h300);
    vt[28] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h300);
    vt[29] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 0, 32'h0,  32'h300);
    vt[30] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'hF0, 32'h300);
    // fifo_empty toggling every cycle
    vt[31] = mkv(1, 0, 32'h0,     1, 4, 32'h60, 0, 0, 0, 32'h0,  32'h304);
    vt[32] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h304);
    vt[33] = mkv(1, 0, 32'h0,     1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h304);
    vt[34] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 1, 32'h60, 32'h304);
    vt[35] = mkv(1, 0, 32'h0,     1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h308);
    vt[36] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 1, 32'h61, 32'h308);
    vt[37] = mkv(1, 0, 32'h0,     1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h30C);
    vt[38] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  1, 0, 1, 32'h62, 32'h30C);
    vt[39] = mkv(1, 0, 32'h0,     1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h310);
    vt[40] = mkv(1, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'h63, 32'h310);
    vt[41] = mkv(1, 0, 32'h0,     1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h314);
    // refill before a mid-stream reset
    vt[42] = mkv(0, 0, 32'h0,     0, 2, 32'h70, 1, 0, 0, 32'h0,  32'h314);
    vt[43] = mkv(0, 0, 32'h0,     0, 0, 32'h0,  1, 0, 0, 32'h0,  32'h314);
    vt[44] = mkv(0, 0, 32'h0,     0, 0, 32'h0,  0, 0, 1, 32'h70, 32'h314);

    // wrap instance tracks the main PC shifted by -8 until the first branch
    vt[1].c_wrap = 1'b1; vt[1].e_pc_w = 32'hFFFF_FFF8;
    vt[2].c_wrap = 1'b1; vt[2].e_pc_w = 32'hFFFF_FFF8;
    vt[3].c_wrap = 1'b1; vt[3].e_pc_w = 32'hFFFF_FFF8;
    vt[4].c_wrap = 1'b1; vt[4].e_pc_w = 32'hFFFF_FFFC;
    vt[5].c_wrap = 1'b1; vt[5].e_pc_w = 32'h0000_0000;
    vt[6].c_wrap = 1'b1; vt[6].e_pc_w = 32'h0000_0004;

    fmem[0] = 32'hA0; fmem[1] = 32'hA1; fmem[2] = 32'hA2;
    wptr = 3;

    // reset held with FIFO non-empty
    @(negedge clk);
    #1;
    chk("reset rd_enable", {31'b0, rd_enable}, 32'h0);
    chk("reset fifo_clear", {31'b0, fifo_clear}, 32'h0);
    chk("reset inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("reset inst", inst, 32'h0);
    chk("reset inst_pc", inst_pc, 32'h0);
    chk("reset wrap inst_pc", inst_pc_w, 32'hFFFF_FFF8);

    // release mid-cycle: this cycle is RST
    #1 reset = 1'b1;
    #1;
    chk("rst-state rd_enable", {31'b0, rd_enable}, 32'h0);
    chk("rst-state inst_valid", {31'b0, inst_valid}, 32'h0);

    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      inst_ready    = vt[i].rdy;
      branch_valid  = vt[i].br;
      branch_target = vt[i].tgt;
      force_empty   = vt[i].fe;
      for (int k = 0; k < vt[i].np; k++) begin
        fmem[wptr] = vt[i].pb + 32'(k);
        wptr = wptr + 1;
      end
      #1;
      chk($sformatf("c%0d rd_enable", i), {31'b0, rd_enable}, {31'b0, vt[i].e_rd});
      chk($sformatf("c%0d fifo_clear", i), {31'b0, fifo_clear}, {31'b0, vt[i].e_clr});
      chk($sformatf("c%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vt[i].e_iv});
      if (vt[i].e_iv) begin
        chk($sformatf("c%0d inst", i), inst, vt[i].e_inst);
      end
      chk($sformatf("c%0d inst_pc", i), inst_pc, vt[i].e_pc);
      if (vt[i].c_wrap) begin
        chk($sformatf("c%0d wrap inst_pc", i), inst_pc_w, vt[i].e_pc_w);
      end
    end

    // asynchronous reset in the middle of a cycle with data buffered
    #2 reset = 1'b0;
    #1;
    chk("midrst rd_enable", {31'b0, rd_enable}, 32'h0);
    chk("midrst fifo_clear", {31'b0, fifo_clear}, 32'h0);
    chk("midrst inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("midrst inst", inst, 32'h0);
    chk("midrst inst_pc", inst_pc, 32'h0);
    chk("midrst wrap inst_pc", inst_pc_w, 32'hFFFF_FFF8);
    chk("midrst wrap inst_valid", {31'b0, inst_valid_w}, 32'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
